// File: rtl/rotate_pkg.sv
// Shared command and state encodings for the rotating chase-display sequencer.
package rotate_pkg;

    typedef enum logic [1:0] {
        OP_START = 2'd0,
        OP_PAUSE = 2'd1,
        OP_STOP  = 2'd2,
        OP_RATE  = 2'd3
    } cmd_op_e;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        HOMING = 2'd3
    } seq_state_e;

endpackage

// File: rtl/rate_divider.sv
// Step-rate divider: holds the programmed clocks-per-step and flags the terminal count.
module rate_divider #(
    parameter int unsigned      DIV_W        = 24,
    parameter logic [DIV_W-1:0] DEFAULT_RATE = DIV_W'(50)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             advance,
    input  logic             clear,
    input  logic             rate_we,
    input  logic [DIV_W-1:0] rate_wdata,
    output logic             tick_c
);

    logic [DIV_W-1:0] count_q, count_d;
    logic [DIV_W-1:0] rate_q, rate_d;

    // rate_q is never zero, so rate_q-1 cannot underflow
    always_comb begin
        tick_c  = advance && (count_q >= (rate_q - DIV_W'(1)));
        count_d = count_q;
        rate_d  = rate_q;
        if (clear) begin
            count_d = '0;
        end else if (tick_c) begin
            count_d = '0;
        end else if (advance) begin
            count_d = count_q + DIV_W'(1);
        end
        if (rate_we) begin
            rate_d = (rate_wdata == '0) ? DIV_W'(1) : rate_wdata;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            rate_q  <= DEFAULT_RATE;
        end else begin
            count_q <= count_d;
            rate_q  <= rate_d;
        end
    end

endmodule

// File: rtl/rotate_sequencer.sv
// Command-driven sequencer for the rotating 7-segment chase: owns run state,
// direction and digit position, and drives the active-low digit enables.
module rotate_sequencer
    import rotate_pkg::*;
#(
    parameter int unsigned      NUM_DIGITS   = 7,
    parameter int unsigned      DIV_W        = 24,
    parameter logic [DIV_W-1:0] DEFAULT_RATE = DIV_W'(50)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          cmd_valid,
    output logic                          cmd_ready,
    input  logic [1:0]                    cmd_op,
    input  logic                          cmd_dir,
    input  logic [DIV_W-1:0]              cmd_data,
    output logic                          en,
    output logic                          cw,
    output logic [$clog2(NUM_DIGITS)-1:0] pos,
    output logic [NUM_DIGITS-1:0]         digit_an,
    output logic                          step,
    output logic                          lap_done,
    output logic                          busy
);

    localparam int unsigned          POS_W    = $clog2(NUM_DIGITS);
    localparam logic [POS_W-1:0]     POS_LAST = POS_W'(NUM_DIGITS - 1);

    seq_state_e            state_q, state_d;
    logic                  cw_q, cw_d;
    logic [POS_W-1:0]      pos_q, pos_d;
    logic [NUM_DIGITS-1:0] digit_an_q, digit_an_d;
    logic                  en_q, en_d;
    logic                  step_q, step_d;
    logic                  lap_done_q, lap_done_d;
    logic                  busy_q, busy_d;
    logic                  cmd_ready_q, cmd_ready_d;

    logic                  accept_c;
    logic                  tick_c;
    cmd_op_e               op_c;

    assign accept_c = cmd_valid && cmd_ready_q;
    assign op_c     = cmd_op_e'(cmd_op);

    rate_divider #(
        .DIV_W        (DIV_W),
        .DEFAULT_RATE (DEFAULT_RATE)
    ) u_rate_divider (
        .clk        (clk),
        .reset      (reset),
        .advance    ((state_q == RUN) || (state_q == HOMING)),
        .clear      (state_q == IDLE),
        .rate_we    (accept_c && (op_c == OP_RATE)),
        .rate_wdata (cmd_data),
        .tick_c     (tick_c)
    );

    // A step always uses the pre-command direction; commands only affect cw_d.
    always_comb begin
        state_d = state_q;
        cw_d    = cw_q;
        pos_d   = pos_q;

        if (tick_c) begin
            if (cw_q) begin
                pos_d = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);
            end else begin
                pos_d = (pos_q == '0) ? POS_LAST : pos_q - POS_W'(1);
            end
        end

        unique case (state_q)
            IDLE: begin
                if (accept_c && (op_c == OP_START)) begin
                    state_d = RUN;
                    cw_d    = cmd_dir;
                    pos_d   = '0;
                end
            end
            RUN: begin
                if (accept_c) begin
                    unique case (op_c)
                        OP_START: cw_d    = cmd_dir;
                        OP_PAUSE: state_d = PAUSE;
                        OP_STOP:  state_d = (pos_d == '0) ? IDLE : HOMING;
                        default:  state_d = RUN;
                    endcase
                end
            end
            PAUSE: begin
                if (accept_c) begin
                    unique case (op_c)
                        OP_START: begin
                            state_d = RUN;
                            cw_d    = cmd_dir;
                        end
                        OP_STOP:  state_d = (pos_d == '0) ? IDLE : HOMING;
                        default:  state_d = PAUSE;
                    endcase
                end
            end
            HOMING: begin
                if (tick_c && (pos_d == '0)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        en_d        = (state_d != IDLE);
        busy_d      = (state_d != IDLE);
        cmd_ready_d = (state_d != HOMING);
        step_d      = tick_c;
        lap_done_d  = tick_c && (pos_d == '0);

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            digit_an_d[i] = !(en_d && (i == (int'(NUM_DIGITS) - 1 - int'(pos_d))));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cw_q        <= 1'b1;
            pos_q       <= '0;
            digit_an_q  <= '1;
            en_q        <= 1'b0;
            step_q      <= 1'b0;
            lap_done_q  <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cw_q        <= cw_d;
            pos_q       <= pos_d;
            digit_an_q  <= digit_an_d;
            en_q        <= en_d;
            step_q      <= step_d;
            lap_done_q  <= lap_done_d;
            busy_q      <= busy_d;
            cmd_ready_q <= cmd_ready_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign en        = en_q;
    assign cw        = cw_q;
    assign pos       = pos_q;
    assign digit_an  = digit_an_q;
    assign step      = step_q;
    assign lap_done  = lap_done_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_rotate_sequencer.sv
// Directed self-checking bench for rotate_sequencer with NUM_DIGITS=7.
module tb_rotate_sequencer;
    import rotate_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_dir = 1'b0;
    logic [23:0] cmd_data = 24'd0;
    logic        cmd_ready, en, cw, step, lap_done, busy;
    logic [2:0]  pos;
    logic [6:0]  digit_an;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rotate_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cmd_dir   (cmd_dir),
        .cmd_data  (cmd_data),
        .en        (en),
        .cw        (cw),
        .pos       (pos),
        .digit_an  (digit_an),
        .step      (step),
        .lap_done  (lap_done),
        .busy      (busy)
    );

    function automatic logic [6:0] an_of(input int p);
        logic [6:0] v;
        v = 7'h7F;
        v[6-p] = 1'b0;
        return v;
    endfunction

    task automatic do_reset();
        cmd_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Called at a negedge; returns at the negedge after the accepting posedge.
    task automatic send(input logic [1:0] op, input logic dir, input logic [23:0] data);
        int n;
        n = 0;
        cmd_valid = 1'b1;
        cmd_op = op;
        cmd_dir = dir;
        cmd_data = data;
        while (cmd_ready !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_ready_timeout: cmd_ready=%b expected 1", cmd_ready);
        end
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (en !== 1'b0 || cw !== 1'b1 || pos !== 3'd0 || digit_an !== 7'b1111111 ||
            cmd_ready !== 1'b1 || busy !== 1'b0 || step !== 1'b0 || lap_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_values: en=%b cw=%b pos=%0d an=%b rdy=%b busy=%b step=%b lap=%b expected 0 1 0 1111111 1 0 0 0",
                     en, cw, pos, digit_an, cmd_ready, busy, step, lap_done);
        end
    endtask

    task automatic test_cw_rate3();
        do_reset();
        send(OP_RATE, 1'b0, 24'd3);
        send(OP_START, 1'b1, 24'd0);
        checks++;
        if (en !== 1'b1 || busy !== 1'b1 || pos !== 3'd0 || digit_an !== 7'b0111111 || cw !== 1'b1) begin
            errors++;
            $display("FAIL cw_start: en=%b busy=%b pos=%0d an=%b cw=%b expected 1 1 0 0111111 1",
                     en, busy, pos, digit_an, cw);
        end
        for (int k = 1; k <= 7; k++) begin
            repeat (2) begin
                @(negedge clk);
                checks++;
                if (step !== 1'b0) begin
                    errors++;
                    $display("FAIL cw_no_step: step=%b expected 0 before step %0d", step, k);
                end
            end
            @(negedge clk);
            checks++;
            if (step !== 1'b1 || pos !== 3'(k % 7) || digit_an !== an_of(k % 7) ||
                lap_done !== (k == 7)) begin
                errors++;
                $display("FAIL cw_step%0d: step=%b pos=%0d an=%b lap=%b expected 1 %0d %b %b",
                         k, step, pos, digit_an, lap_done, k % 7, an_of(k % 7), (k == 7));
            end
        end
    endtask

    task automatic test_ccw_rate2();
        int p;
        do_reset();
        send(OP_RATE, 1'b0, 24'd2);
        send(OP_START, 1'b0, 24'd0);
        checks++;
        if (cw !== 1'b0 || pos !== 3'd0) begin
            errors++;
            $display("FAIL ccw_start: cw=%b pos=%0d expected 0 0", cw, pos);
        end
        p = 0;
        for (int k = 1; k <= 7; k++) begin
            p = (p == 0) ? 6 : p - 1;
            @(negedge clk);
            checks++;
            if (step !== 1'b0) begin
                errors++;
                $display("FAIL ccw_no_step: step=%b expected 0 before step %0d", step, k);
            end
            @(negedge clk);
            checks++;
            if (step !== 1'b1 || pos !== 3'(p) || digit_an !== an_of(p) || lap_done !== (p == 0)) begin
                errors++;
                $display("FAIL ccw_step%0d: step=%b pos=%0d an=%b lap=%b expected 1 %0d %b %b",
                         k, step, pos, digit_an, lap_done, p, an_of(p), (p == 0));
            end
        end
    endtask

    task automatic test_pause();
        do_reset();
        send(OP_RATE, 1'b0, 24'd3);
        send(OP_START, 1'b1, 24'd0);
        repeat (9) @(negedge clk);
        checks++;
        if (pos !== 3'd3) begin
            errors++;
            $display("FAIL pause_reach3: pos=%0d expected 3", pos);
        end
        @(negedge clk);
        send(OP_PAUSE, 1'b0, 24'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (pos !== 3'd3 || en !== 1'b1 || step !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL pause_hold%0d: pos=%0d en=%b step=%b busy=%b expected 3 1 0 1",
                         i, pos, en, step, busy);
            end
        end
        send(OP_START, 1'b1, 24'd0);
        @(negedge clk);
        checks++;
        if (step !== 1'b1 || pos !== 3'd4 || cw !== 1'b1) begin
            errors++;
            $display("FAIL pause_resume: step=%b pos=%0d cw=%b expected 1 4 1", step, pos, cw);
        end
    endtask

    task automatic test_stop_homing();
        int exp_pos[3] = '{5, 6, 0};
        do_reset();
        send(OP_RATE, 1'b0, 24'd2);
        send(OP_START, 1'b1, 24'd0);
        repeat (8) @(negedge clk);
        checks++;
        if (pos !== 3'd4) begin
            errors++;
            $display("FAIL stop_reach4: pos=%0d expected 4", pos);
        end
        send(OP_STOP, 1'b0, 24'd0);
        checks++;
        if (cmd_ready !== 1'b0 || busy !== 1'b1 || en !== 1'b1 || pos !== 3'd4) begin
            errors++;
            $display("FAIL stop_homing: rdy=%b busy=%b en=%b pos=%0d expected 0 1 1 4",
                     cmd_ready, busy, en, pos);
        end
        for (int i = 0; i < 3; i++) begin
            if (i > 0) begin
                @(negedge clk);
                checks++;
                if (step !== 1'b0 || cmd_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL homing_gap%0d: step=%b rdy=%b expected 0 0", i, step, cmd_ready);
                end
            end
            @(negedge clk);
            checks++;
            if (step !== 1'b1 || pos !== 3'(exp_pos[i])) begin
                errors++;
                $display("FAIL homing_step%0d: step=%b pos=%0d expected 1 %0d", i, step, pos, exp_pos[i]);
            end
        end
        checks++;
        if (en !== 1'b0 || digit_an !== 7'b1111111 || busy !== 1'b0 || cmd_ready !== 1'b1 || lap_done !== 1'b1) begin
            errors++;
            $display("FAIL homing_idle: en=%b an=%b busy=%b rdy=%b lap=%b expected 0 1111111 0 1 1",
                     en, digit_an, busy, cmd_ready, lap_done);
        end
        @(negedge clk);
        checks++;
        if (step !== 1'b0 || pos !== 3'd0 || lap_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_quiet: step=%b pos=%0d lap=%b expected 0 0 0", step, pos, lap_done);
        end
    endtask

    task automatic test_stop_same_cycle();
        do_reset();
        send(OP_RATE, 1'b0, 24'd2);
        send(OP_START, 1'b1, 24'd0);
        repeat (13) @(negedge clk);
        checks++;
        if (pos !== 3'd6) begin
            errors++;
            $display("FAIL stopsame_reach6: pos=%0d expected 6", pos);
        end
        send(OP_STOP, 1'b0, 24'd0);
        checks++;
        if (step !== 1'b1 || pos !== 3'd0 || busy !== 1'b0 || en !== 1'b0 ||
            cmd_ready !== 1'b1 || lap_done !== 1'b1 || digit_an !== 7'b1111111) begin
            errors++;
            $display("FAIL stop_same_cycle: step=%b pos=%0d busy=%b en=%b rdy=%b lap=%b an=%b expected 1 0 0 0 1 1 1111111",
                     step, pos, busy, en, cmd_ready, lap_done, digit_an);
        end
    endtask

    task automatic test_rate0_and_async_reset();
        int p;
        int early;
        do_reset();
        send(OP_RATE, 1'b0, 24'd0);
        send(OP_START, 1'b0, 24'd0);
        for (int k = 1; k <= 8; k++) begin
            p = (7 - (k % 7)) % 7;
            @(negedge clk);
            checks++;
            if (step !== 1'b1 || pos !== 3'(p) || lap_done !== (p == 0)) begin
                errors++;
                $display("FAIL rate0_step%0d: step=%b pos=%0d lap=%b expected 1 %0d %b",
                         k, step, pos, lap_done, p, (p == 0));
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if (en !== 1'b0 || cw !== 1'b1 || pos !== 3'd0 || digit_an !== 7'b1111111 ||
            cmd_ready !== 1'b1 || busy !== 1'b0 || step !== 1'b0 || lap_done !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: en=%b cw=%b pos=%0d an=%b rdy=%b busy=%b step=%b lap=%b expected 0 1 0 1111111 1 0 0 0",
                     en, cw, pos, digit_an, cmd_ready, busy, step, lap_done);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        send(OP_START, 1'b1, 24'd0);
        early = 0;
        repeat (49) begin
            @(negedge clk);
            if (step !== 1'b0) early++;
        end
        checks++;
        if (early != 0) begin
            errors++;
            $display("FAIL default_rate_early: %0d early steps expected 0", early);
        end
        @(negedge clk);
        checks++;
        if (step !== 1'b1 || pos !== 3'd1) begin
            errors++;
            $display("FAIL default_rate_step: step=%b pos=%0d expected 1 1", step, pos);
        end
    endtask

    initial begin
        test_reset();
        test_cw_rate3();
        test_ccw_rate2();
        test_pause();
        test_stop_homing();
        test_stop_same_cycle();
        test_rate0_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
